// File: rtl/vga_fb_write_scheduler_pkg.sv
// Shared types and framebuffer geometry for the VGA framebuffer write scheduler.
package vga_fb_write_scheduler_pkg;

    localparam int FB_WIDTH  = 640;
    localparam int FB_HEIGHT = 480;
    localparam int FB_WORDS  = FB_WIDTH * FB_HEIGHT;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/vga_fb_write_scheduler_arb.sv
// Two-way round-robin arbiter producing a one-hot grant from two request valids.
module rr_arbiter2
    import vga_fb_write_scheduler_pkg::*;
(
    input  logic       i_valid0,
    input  logic       i_valid1,
    input  logic       i_last,    // 1: requester 1 was granted most recently
    output logic [1:0] o_grant
);

    // Lone requester wins outright; on contention the one not served last wins.
    always_comb begin
        o_grant = 2'b00;
        if (i_valid0 && i_valid1) begin
            o_grant = i_last ? 2'b01 : 2'b10;
        end else if (i_valid0) begin
            o_grant = 2'b01;
        end else if (i_valid1) begin
            o_grant = 2'b10;
        end else begin
            o_grant = 2'b00;
        end
    end

endmodule

// File: rtl/vga_fb_write_scheduler.sv
// Schedules framebuffer writes from two requesters and a full-screen clear engine
// onto a single registered write port.
module vga_fb_write_scheduler
    import vga_fb_write_scheduler_pkg::*;
#(
    parameter int FB_WORDS = vga_fb_write_scheduler_pkg::FB_WORDS,
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 8
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              oWREN,
    output logic [ADDR_W-1:0] oADDR,
    output logic [DATA_W-1:0] oDATA,
    output logic              oerr_addr
);

    localparam logic [ADDR_W:0]   C_LIMIT = (ADDR_W+1)'(FB_WORDS);
    localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(FB_WORDS - 1);

    state_t            r_state,     w_state_nxt;
    logic [ADDR_W-1:0] r_clr_cnt,   w_clr_cnt_nxt;
    logic [DATA_W-1:0] r_clr_color, w_clr_color_nxt;
    logic              r_last,      w_last_nxt;
    logic              r_wren,      w_wren_nxt;
    logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
    logic [DATA_W-1:0] r_data,      w_data_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_err,       w_err_nxt;
    logic              w_ready0;
    logic              w_ready1;
    logic [1:0]        w_grant;
    logic              w_in0;
    logic              w_in1;

    rr_arbiter2 u_arb (
        .i_valid0 (req0_valid),
        .i_valid1 (req1_valid),
        .i_last   (r_last),
        .o_grant  (w_grant)
    );

    assign w_in0 = ({1'b0, req0_addr} < C_LIMIT);
    assign w_in1 = ({1'b0, req1_addr} < C_LIMIT);

    // Next-state, grant and write-port decode for arbitration and clearing.
    always_comb begin
        w_state_nxt     = r_state;
        w_clr_cnt_nxt   = r_clr_cnt;
        w_clr_color_nxt = r_clr_color;
        w_last_nxt      = r_last;
        w_wren_nxt      = 1'b0;
        w_addr_nxt      = r_addr;
        w_data_nxt      = r_data;
        w_done_nxt      = 1'b0;
        w_err_nxt       = 1'b0;
        w_ready0        = 1'b0;
        w_ready1        = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (clr_start) begin
                    w_clr_color_nxt = clr_color;
                    w_clr_cnt_nxt   = '0;
                    w_state_nxt     = ST_CLEAR;
                end else if (w_grant[0]) begin
                    w_ready0   = 1'b1;
                    w_last_nxt = 1'b0;
                    if (w_in0) begin
                        w_wren_nxt = 1'b1;
                        w_addr_nxt = req0_addr;
                        w_data_nxt = req0_data;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else if (w_grant[1]) begin
                    w_ready1   = 1'b1;
                    w_last_nxt = 1'b1;
                    if (w_in1) begin
                        w_wren_nxt = 1'b1;
                        w_addr_nxt = req1_addr;
                        w_data_nxt = req1_data;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_ARB;
                end
            end
            ST_CLEAR: begin
                // The cycle showing the final address on oADDR is still CLEAR.
                if (r_done) begin
                    w_state_nxt = ST_ARB;
                end else begin
                    w_wren_nxt = 1'b1;
                    w_addr_nxt = r_clr_cnt;
                    w_data_nxt = r_clr_color;
                    if (r_clr_cnt == C_LAST) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    // State, clear engine, arbitration pointer and registered write port.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            r_state     <= ST_ARB;
            r_clr_cnt   <= '0;
            r_clr_color <= '0;
            r_last      <= 1'b1;
            r_wren      <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
            r_clr_color <= w_clr_color_nxt;
            r_last      <= w_last_nxt;
            r_wren      <= w_wren_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign req0_ready = iRST_n && w_ready0;
    assign req1_ready = iRST_n && w_ready1;
    assign clr_busy   = (r_state == ST_CLEAR);
    assign clr_done   = r_done;
    assign oWREN      = r_wren;
    assign oADDR      = r_addr;
    assign oDATA      = r_data;
    assign oerr_addr  = r_err;

endmodule

// File: tb/tb_vga_fb_write_scheduler.sv
// Self-checking bench for vga_fb_write_scheduler using a reduced framebuffer depth.
module tb_vga_fb_write_scheduler;

    localparam int FBW = 1200;
    localparam int AW  = 11;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr, oADDR;
    logic [DW-1:0] req0_data, req1_data, clr_color, oDATA;
    logic          clr_start, clr_busy, clr_done, oWREN, oerr_addr;

    int n_pass  = 0;
    int n_total = 0;

    vga_fb_write_scheduler #(.FB_WORDS(FBW), .ADDR_W(AW), .DATA_W(DW)) dut (
        .iVGA_CLK   (clk),
        .iRST_n     (rst_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .clr_start  (clr_start),
        .clr_color  (clr_color),
        .clr_busy   (clr_busy),
        .clr_done   (clr_done),
        .oWREN      (oWREN),
        .oADDR      (oADDR),
        .oDATA      (oDATA),
        .oerr_addr  (oerr_addr)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        clr_start  = 1'b0; clr_color = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle_inputs();
        #2 rst_n = 1'b0;
        req0_valid = 1'b1; req0_addr = 11'd3;
        req1_valid = 1'b1; req1_addr = 11'd4;
        #1;
        n_total++;
        if (oWREN !== 1'b0 || oADDR !== 11'd0 || oDATA !== 8'd0 || clr_busy !== 1'b0 ||
            clr_done !== 1'b0 || oerr_addr !== 1'b0) begin
            $display("FAIL reset_outputs: got wren=%b addr=%0d data=%0h busy=%b done=%b err=%b, expected all 0",
                     oWREN, oADDR, oDATA, clr_busy, clr_done, oerr_addr);
        end else n_pass++;
        repeat (2) @(negedge clk);
        n_total++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || oWREN !== 1'b0) begin
            $display("FAIL reset_ready: got r0=%b r1=%b wren=%b, expected 0 0 0", req0_ready, req1_ready, oWREN);
        end else n_pass++;
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 11'd5; req0_data = 8'h3C;
        #1;
        n_total++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            $display("FAIL single_ready: got r0=%b r1=%b, expected 1 0", req0_ready, req1_ready);
        end else n_pass++;
        @(negedge clk);
        req0_valid = 1'b0;
        n_total++;
        if (oWREN !== 1'b1 || oADDR !== 11'd5 || oDATA !== 8'h3C) begin
            $display("FAIL single_write: got wren=%b addr=%0d data=%0h, expected 1 5 3c", oWREN, oADDR, oDATA);
        end else n_pass++;
        @(negedge clk);
        n_total++;
        if (oWREN !== 1'b0) begin
            $display("FAIL single_idle: got wren=%b, expected 0", oWREN);
        end else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 11'd10; req0_data = 8'h11;
        req1_valid = 1'b1; req1_addr = 11'd20; req1_data = 8'h22;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_total++;
            if (req0_ready !== (k % 2 == 0) || req1_ready !== (k % 2 == 1)) begin
                $display("FAIL b2b_grant%0d: got r0=%b r1=%b, expected r0=%b", k, req0_ready, req1_ready, (k % 2 == 0));
            end else n_pass++;
            @(negedge clk);
            n_total++;
            if (oWREN !== 1'b1 || oADDR !== ((k % 2 == 0) ? 11'd10 : 11'd20) ||
                oDATA !== ((k % 2 == 0) ? 8'h11 : 8'h22)) begin
                $display("FAIL b2b_write%0d: got wren=%b addr=%0d data=%0h", k, oWREN, oADDR, oDATA);
            end else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_oob();
        @(negedge clk);
        req1_valid = 1'b1; req1_addr = 11'(FBW); req1_data = 8'h55;
        #1;
        n_total++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            $display("FAIL oob_ready: got r0=%b r1=%b, expected 0 1", req0_ready, req1_ready);
        end else n_pass++;
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_addr = 11'(FBW - 1); req0_data = 8'h66;
        n_total++;
        if (oerr_addr !== 1'b1 || oWREN !== 1'b0) begin
            $display("FAIL oob_err: got err=%b wren=%b, expected 1 0", oerr_addr, oWREN);
        end else n_pass++;
        @(negedge clk);
        req0_valid = 1'b0;
        n_total++;
        if (oerr_addr !== 1'b0 || oWREN !== 1'b1 || oADDR !== 11'(FBW - 1) || oDATA !== 8'h66) begin
            $display("FAIL oob_last_in_range: got err=%b wren=%b addr=%0d data=%0h, expected 0 1 %0d 66",
                     oerr_addr, oWREN, oADDR, oDATA, FBW - 1);
        end else n_pass++;
    endtask

    task automatic test_random();
        int            fav;
        int            g;
        logic          exp_wr, exp_er;
        logic [AW-1:0] exp_a;
        logic [DW-1:0] exp_d;
        do_reset();
        fav = 0; exp_wr = 1'b0; exp_er = 1'b0; exp_a = '0; exp_d = '0;
        for (int i = 0; i <= 250; i++) begin
            @(negedge clk);
            n_total++;
            if (oWREN !== exp_wr || oerr_addr !== exp_er || (exp_wr && (oADDR !== exp_a || oDATA !== exp_d))) begin
                $display("FAIL rand_write%0d: got wren=%b err=%b addr=%0d data=%0h, expected %b %b %0d %0h",
                         i, oWREN, oerr_addr, oADDR, oDATA, exp_wr, exp_er, exp_a, exp_d);
            end else n_pass++;
            if (i == 250) break;
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_addr  = AW'($urandom_range(0, FBW + 200));
            req1_addr  = AW'($urandom_range(0, FBW + 200));
            req0_data  = DW'($urandom);
            req1_data  = DW'($urandom);
            #1;
            if (req0_valid && req1_valid) g = fav;
            else if (req0_valid)          g = 0;
            else if (req1_valid)          g = 1;
            else                          g = -1;
            n_total++;
            if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
                $display("FAIL rand_grant%0d: got r0=%b r1=%b, expected grant %0d", i, req0_ready, req1_ready, g);
            end else n_pass++;
            exp_wr = 1'b0; exp_er = 1'b0;
            if (g >= 0) begin
                exp_a = (g == 0) ? req0_addr : req1_addr;
                exp_d = (g == 0) ? req0_data : req1_data;
                if (int'(exp_a) >= FBW) exp_er = 1'b1;
                else                    exp_wr = 1'b1;
                fav = 1 - g;
            end
        end
        idle_inputs();
    endtask

    task automatic run_clear(input logic [DW-1:0] color, input int restart_at, input int reset_at,
                             output logic rdy_start, output int nwr, output int nbad, output int ndone,
                             output logic [AW-1:0] done_addr, output int busy_cyc,
                             output logic rdy_after, output logic rst_ok);
        nwr = 0; nbad = 0; ndone = 0; done_addr = '0; busy_cyc = 0; rdy_after = 1'b0; rst_ok = 1'b1;
        @(negedge clk);
        clr_start = 1'b1; clr_color = color;
        req0_valid = 1'b1; req0_addr = 11'd77; req0_data = 8'hA5;
        #1 rdy_start = req0_ready | req1_ready;
        @(negedge clk);
        clr_color = ~color;
        for (int i = 0; i < FBW + 20; i++) begin
            if (i > 0) @(negedge clk);
            clr_start = 1'b0;
            if (!clr_busy) begin
                rdy_after = req0_ready;
                break;
            end
            busy_cyc++;
            if (req0_ready || req1_ready) nbad++;
            if (oWREN) begin
                if (oADDR !== AW'(nwr) || oDATA !== color) nbad++;
                nwr++;
            end
            if (clr_done) begin
                ndone++;
                done_addr = oADDR;
            end
            if (restart_at >= 0 && nwr == restart_at) begin
                clr_start = 1'b1;
            end
            if (reset_at >= 0 && nwr == reset_at + 1) begin
                rst_n = 1'b0;
                #1;
                if (oWREN || clr_busy || clr_done) rst_ok = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (oWREN || clr_busy || clr_done || req0_ready) rst_ok = 1'b0;
                end
                rst_n = 1'b1;
                #1 rdy_after = req0_ready;
                break;
            end
        end
    endtask

    task automatic check_clear_result(input string name, input int exp_nwr, input int exp_ndone,
                                      input int exp_busy, input logic rdy_start, input int nwr,
                                      input int nbad, input int ndone, input logic [AW-1:0] done_addr,
                                      input int busy_cyc, input logic rdy_after);
        n_total++;
        if (rdy_start !== 1'b0) $display("FAIL %s_start_ready: got %b, expected 0", name, rdy_start);
        else n_pass++;
        n_total++;
        if (nwr != exp_nwr || nbad != 0) $display("FAIL %s_writes: got %0d writes %0d bad, expected %0d writes 0 bad", name, nwr, nbad, exp_nwr);
        else n_pass++;
        n_total++;
        if (ndone != exp_ndone || (exp_ndone == 1 && done_addr !== 11'(FBW - 1)))
            $display("FAIL %s_done: got %0d pulses at %0d, expected %0d", name, ndone, done_addr, exp_ndone);
        else n_pass++;
        n_total++;
        if (exp_busy >= 0 && busy_cyc != exp_busy) $display("FAIL %s_busy_len: got %0d, expected %0d", name, busy_cyc, exp_busy);
        else n_pass++;
        n_total++;
        if (rdy_after !== 1'b1) $display("FAIL %s_ready_after: got %b, expected 1", name, rdy_after);
        else n_pass++;
        @(negedge clk);
        req0_valid = 1'b0;
        n_total++;
        if (oWREN !== 1'b1 || oADDR !== 11'd77 || oDATA !== 8'hA5)
            $display("FAIL %s_post_write: got wren=%b addr=%0d data=%0h, expected 1 77 a5", name, oWREN, oADDR, oDATA);
        else n_pass++;
    endtask

    task automatic test_clear();
        logic rs, ra, rk; int nw, nb, nd, bc; logic [AW-1:0] da;
        run_clear(8'h07, -1, -1, rs, nw, nb, nd, da, bc, ra, rk);
        check_clear_result("clear", FBW, 1, FBW + 1, rs, nw, nb, nd, da, bc, ra);
    endtask

    task automatic test_clear_restart();
        logic rs, ra, rk; int nw, nb, nd, bc; logic [AW-1:0] da;
        run_clear(8'h5A, 1000, -1, rs, nw, nb, nd, da, bc, ra, rk);
        check_clear_result("restart", FBW, 1, FBW + 1, rs, nw, nb, nd, da, bc, ra);
    endtask

    task automatic test_clear_reset();
        logic rs, ra, rk; int nw, nb, nd, bc; logic [AW-1:0] da;
        run_clear(8'hC3, -1, 500, rs, nw, nb, nd, da, bc, ra, rk);
        n_total++;
        if (rk !== 1'b1) $display("FAIL abort_quiet: got %b, expected 1 (no write/busy/done during reset)", rk);
        else n_pass++;
        check_clear_result("abort", 501, 0, -1, rs, nw, nb, nd, da, bc, ra);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_oob();
        test_random();
        test_clear();
        test_clear_restart();
        test_clear_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
